// File: rtl/imem_loader_master.sv
// imem_loader_master: Avalon-MM master that packs a host byte stream
// little-endian into 32-bit words, writes them into an on-chip instruction
// memory and optionally reads the region back to compare additive checksums.
module imem_loader_master #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_VERIFY_RD,
        S_VERIFY_CAP,
        S_DONE
    } state_t;

    localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(DEPTH);

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_idx;
    logic [1:0]          r_byteCnt;
    logic [31:0]         r_word;
    logic [31:0]         r_sumW;
    logic [31:0]         r_sumR;
    logic                r_error;
    logic [ADDR_W+1:0]   w_rangeEnd;
    logic                w_rangeBad;
    logic                w_lastWord;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_sumRNext;

    // The requested region must be non-empty and end at or before the top of memory.
    assign w_rangeEnd = {2'b00, base_addr} + {1'b0, word_count};
    assign w_rangeBad = (word_count == '0) || (w_rangeEnd > DEPTH_EXT);
    assign w_lastWord = ((r_idx + (ADDR_W+1)'(1)) == r_count);
    assign w_addr     = r_base + r_idx[ADDR_W-1:0];
    assign w_sumRNext = r_sumR + avm_readdata;

    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;
    assign avm_writedata  = r_word;
    assign error          = r_error;

    // State register; reset abandons any load in progress without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and the bus/handshake strobes, all decoded from the current state.
    always_comb begin
        w_nextState    = r_state;
        s_ready        = 1'b0;
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        done           = 1'b0;
        busy           = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = w_rangeBad ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                s_ready = 1'b1;
                if (s_valid && (r_byteCnt == 2'd3)) begin
                    w_nextState = S_WRITE;
                end
            end
            S_WRITE: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_address    = w_addr;
                if (w_lastWord) begin
                    w_nextState = (VERIFY != 0) ? S_VERIFY_RD : S_DONE;
                end else begin
                    w_nextState = S_COLLECT;
                end
            end
            S_VERIFY_RD: begin
                avm_chipselect = 1'b1;
                avm_address    = w_addr;
                w_nextState    = S_VERIFY_CAP;
            end
            S_VERIFY_CAP: begin
                w_nextState = w_lastWord ? S_DONE : S_VERIFY_RD;
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: latch the job, pack bytes into lanes, walk the index and keep both checksums.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base    <= '0;
            r_count   <= '0;
            r_idx     <= '0;
            r_byteCnt <= '0;
            r_word    <= '0;
            r_sumW    <= '0;
            r_sumR    <= '0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_rangeBad) begin
                            r_error <= 1'b1;
                        end else begin
                            r_base    <= base_addr;
                            r_count   <= word_count;
                            r_error   <= 1'b0;
                            r_idx     <= '0;
                            r_byteCnt <= '0;
                            r_sumW    <= '0;
                            r_sumR    <= '0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (s_valid) begin
                        r_word[{r_byteCnt, 3'b000} +: 8] <= s_data;
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_sumW <= r_sumW + r_word;
                    if (w_lastWord) begin
                        r_idx <= '0;
                    end else begin
                        r_idx <= r_idx + (ADDR_W+1)'(1);
                    end
                end
                S_VERIFY_CAP: begin
                    r_sumR <= w_sumRNext;
                    r_idx  <= r_idx + (ADDR_W+1)'(1);
                    if (w_lastWord) begin
                        r_error <= (w_sumRNext != r_sumW);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
